// File: rtl/sram_wb_slave.sv
// sram_wb_slave
//   Wishbone classic-cycle responder for CPU data memory. It serves every
//   single cyc/stb transfer from an external asynchronous 32-bit SRAM and
//   answers each one with a single-cycle ack.
//
//   Ports
//     clk_i, rst_ni          clock; asynchronous active-low reset
//     wb_cyc_i, wb_stb_i     Wishbone cycle / strobe
//     wb_we_i                1 = write
//     wb_adr_i               byte address (the low byte-address bits are ignored)
//     wb_dat_i, wb_sel_i     write data and byte lanes
//     wb_ack_o               transfer done, one-cycle pulse
//     wb_err_o               address error (address-check build only, else 0)
//     wb_dat_o               read data; byte lanes passed through unchanged
//     sram_addr              SRAM word address
//     sram_data              bidirectional SRAM data bus
//     sram_ce_n/oe_n/we_n    SRAM strobes, active-low
//     sram_be_n              SRAM byte enables, active-low
//
//   Build option
//     SRAM_WB_ADDR_CHECK_EN  When defined, a request with any address bit set
//                            above the SRAM range gets a wb_err_o pulse and
//                            does not touch the SRAM. When undefined, the
//                            upper address bits are ignored and the SRAM aliases.
`timescale 1ns/1ps
module sram_wb_slave #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 20,
  parameter int SRAM_DATA_WIDTH = 32,
  parameter int READ_WAIT       = 1,
  parameter int WRITE_WAIT      = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         wb_cyc_i,
  input  logic                         wb_stb_i,
  input  logic                         wb_we_i,
  input  logic [ADDR_WIDTH-1:0]        wb_adr_i,
  input  logic [DATA_WIDTH-1:0]        wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0]      wb_sel_i,
  output logic                         wb_ack_o,
  output logic                         wb_err_o,
  output logic [DATA_WIDTH-1:0]        wb_dat_o,
  output logic [SRAM_ADDR_WIDTH-1:0]   sram_addr,
  inout  wire  [SRAM_DATA_WIDTH-1:0]   sram_data,
  output logic                         sram_ce_n,
  output logic                         sram_oe_n,
  output logic                         sram_we_n,
  output logic [SRAM_DATA_WIDTH/8-1:0] sram_be_n
);
  localparam int SRAM_BYTES      = SRAM_DATA_WIDTH / 8;
  localparam int SRAM_BYTE_WIDTH = $clog2(SRAM_BYTES);
  localparam int AHI             = SRAM_ADDR_WIDTH + SRAM_BYTE_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_DONE
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic [3:0]                r_cnt, w_cnt_nxt;
  logic                      r_abort, w_abort_nxt;
  logic [SRAM_BYTES-1:0]     r_sel;
  logic [SRAM_DATA_WIDTH-1:0] r_wdat;

  logic                      w_req, w_bad, w_ld, w_cap, w_ack_nxt, w_err_nxt;
  logic                      w_active, w_drive;
  logic [SRAM_BYTES-1:0]     w_sel;
  logic                      w_unused_adr;

  assign w_req = wb_cyc_i & wb_stb_i & ~wb_ack_o;

`ifdef SRAM_WB_ADDR_CHECK_EN
  assign w_bad = |wb_adr_i[ADDR_WIDTH-1:AHI];
`else
  assign w_bad = 1'b0;
`endif

  // Byte-offset bits (and, without the check, the upper bits) never matter.
  assign w_unused_adr = ^{wb_adr_i[ADDR_WIDTH-1:AHI], wb_adr_i[SRAM_BYTE_WIDTH-1:0]};

  // The bus is driven only while a write owns the SRAM; oe_n is high then.
  assign w_drive   = (r_state == S_WR_SETUP) || (r_state == S_WR_PULSE) ||
                     (r_state == S_WR_HOLD);
  assign sram_data = w_drive ? r_wdat : {SRAM_DATA_WIDTH{1'bz}};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_abort_nxt = r_abort;
    w_ld        = 1'b0;
    w_cap       = 1'b0;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    // A write never truncates its we_n pulse; a dropped cyc is only remembered.
    if (w_drive && !wb_cyc_i) w_abort_nxt = 1'b1;
    case (r_state)
      S_IDLE: if (w_req) begin
        if (w_bad) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b1;
        end else begin
          w_ld        = 1'b1;
          w_abort_nxt = 1'b0;
          if (wb_we_i) w_state_nxt = S_WR_SETUP;
          else begin
            w_state_nxt = S_RD;
            w_cnt_nxt   = 4'(READ_WAIT);
          end
        end
      end
      S_RD: begin
        if (!wb_cyc_i) w_state_nxt = S_IDLE;
        else if (r_cnt == 4'd0) begin
          w_state_nxt = S_DONE;
          w_ack_nxt   = 1'b1;
          w_cap       = 1'b1;
        end else w_cnt_nxt = r_cnt - 4'd1;
      end
      S_WR_SETUP: begin
        w_state_nxt = S_WR_PULSE;
        w_cnt_nxt   = 4'(WRITE_WAIT);
      end
      S_WR_PULSE: begin
        if (r_cnt == 4'd0) w_state_nxt = S_WR_HOLD;
        else w_cnt_nxt = r_cnt - 4'd1;
      end
      S_WR_HOLD: begin
        if (r_abort || !wb_cyc_i) w_state_nxt = S_IDLE;
        else begin
          w_state_nxt = S_DONE;
          w_ack_nxt   = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // SRAM strobes are registered from the next state so they switch on the
  // same edge the state does.
  assign w_active = (w_state_nxt == S_RD) || (w_state_nxt == S_WR_SETUP) ||
                    (w_state_nxt == S_WR_PULSE) || (w_state_nxt == S_WR_HOLD);
  assign w_sel    = w_ld ? wb_sel_i : r_sel;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
      wb_dat_o  <= '0;
      sram_addr <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_be_n <= '1;
      r_sel     <= '0;
      r_wdat    <= '0;
    end else begin
      wb_ack_o  <= w_ack_nxt;
      wb_err_o  <= w_err_nxt;
      if (w_cap) wb_dat_o <= sram_data;
      if (w_ld) begin
        sram_addr <= wb_adr_i[AHI-1:SRAM_BYTE_WIDTH];
        r_sel     <= wb_sel_i;
        r_wdat    <= wb_dat_i;
      end
      sram_ce_n <= ~w_active;
      sram_oe_n <= (w_state_nxt != S_RD);
      sram_we_n <= (w_state_nxt != S_WR_PULSE);
      sram_be_n <= w_active ? ~w_sel : '1;
    end
  end
endmodule
